// File: rtl/lut_stream_eval.sv
// Programmable N-input Boolean function evaluator for streaming data.
// Evaluates a runtime-loadable truth table on parallel words or on a sliding serial window.
module lut_stream_eval #(
    parameter int           N       = 4,
    parameter logic [2**N-1:0] TT_INIT = 16'h56E2,
    parameter int           CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [N-1:0]     in_par,
    input  logic             in_ser,
    input  logic             tt_load,
    input  logic [2**N-1:0]  tt_data,
    input  logic             cnt_clr,
    output logic             out,
    output logic             out_valid,
    output logic [N-1:0]     window,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = $clog2(N);
    localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t           state, state_n;
    logic [2**N-1:0]  tt, tt_n;
    logic [N-1:0]     window_n;
    logic [N-1:0]     win_shift;
    logic [FW-1:0]    fill_cnt, fill_n;
    logic             mode_q;
    logic             out_n, out_valid_n;
    logic [CNT_W-1:0] cnt_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            tt        <= TT_INIT;
            window    <= '0;
            fill_cnt  <= '0;
            mode_q    <= 1'b0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            match_cnt <= '0;
        end else begin
            state     <= state_n;
            tt        <= tt_n;
            window    <= window_n;
            fill_cnt  <= fill_n;
            mode_q    <= mode;
            out       <= out_n;
            out_valid <= out_valid_n;
            match_cnt <= cnt_n;
        end
    end

    // Evaluation always reads the current table, so a same-cycle load only affects later inputs.
    always_comb begin
        state_n     = state;
        tt_n        = tt;
        window_n    = window;
        fill_n      = fill_cnt;
        out_n       = out;
        out_valid_n = 1'b0;
        cnt_n       = match_cnt;
        win_shift   = {window[N-2:0], in_ser};

        if (mode != mode_q) begin
            window_n = '0;
            fill_n   = '0;
            state_n  = FILL;
        end else if (in_valid) begin
            if (!mode) begin
                out_n       = tt[in_par];
                out_valid_n = 1'b1;
            end else begin
                window_n = win_shift;
                case (state)
                    FILL: begin
                        if (fill_cnt == FILL_LAST) begin
                            state_n     = RUN;
                            out_n       = tt[win_shift];
                            out_valid_n = 1'b1;
                        end else begin
                            fill_n = fill_cnt + FW'(1);
                        end
                    end
                    RUN: begin
                        out_n       = tt[win_shift];
                        out_valid_n = 1'b1;
                    end
                    default: state_n = FILL;
                endcase
            end
        end

        if (tt_load) begin
            tt_n = tt_data;
        end

        // Clear beats a simultaneous increment; the counter sticks at all-ones.
        if (cnt_clr) begin
            cnt_n = '0;
        end else if (out_valid_n && out_n && !(&match_cnt)) begin
            cnt_n = match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lut_stream_eval.sv
// Testbench for lut_stream_eval: directed scenarios followed by randomized traffic,
// checked against a queue-based reference model of the evaluator.
module tb_lut_stream_eval;

    localparam int          N       = 4;
    localparam logic [15:0] TT_INIT = 16'h56E2;

    logic        clk = 1'b0;
    logic        rst, mode, in_valid, in_ser, tt_load, cnt_clr;
    logic [3:0]  in_par;
    logic [15:0] tt_data;

    logic        out_a, out_valid_a, out_b, out_valid_b;
    logic [3:0]  window_a, window_b;
    logic [7:0]  match_cnt_a;
    logic [1:0]  match_cnt_b;

    logic [15:0] m_tt;
    logic        m_mode, m_out, m_valid;
    bit          hist[$];
    int          m_cnt8, m_cnt2;
    int          n_cmp, n_fail;

    always #5 clk = ~clk;

    lut_stream_eval #(.N(4), .TT_INIT(TT_INIT), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_par(in_par),
        .in_ser(in_ser), .tt_load(tt_load), .tt_data(tt_data), .cnt_clr(cnt_clr),
        .out(out_a), .out_valid(out_valid_a), .window(window_a), .match_cnt(match_cnt_a)
    );

    lut_stream_eval #(.N(4), .TT_INIT(TT_INIT), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_par(in_par),
        .in_ser(in_ser), .tt_load(tt_load), .tt_data(tt_data), .cnt_clr(cnt_clr),
        .out(out_b), .out_valid(out_valid_b), .window(window_b), .match_cnt(match_cnt_b)
    );

    function automatic int winVal();
        int v = 0;
        foreach (hist[i]) v = (v * 2) + int'(hist[i]);
        return v;
    endfunction

    // Reference model: the window is the last N accepted bits since the last restart.
    task automatic modelStep();
        if (rst) begin
            m_tt = TT_INIT; m_mode = 1'b0; hist.delete();
            m_out = 1'b0; m_valid = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            m_valid = 1'b0;
            if (mode != m_mode) begin
                hist.delete();
                m_mode = mode;
            end else if (in_valid) begin
                if (!mode) begin
                    m_out = m_tt[in_par]; m_valid = 1'b1;
                end else begin
                    hist.push_back(in_ser);
                    if (hist.size() > N) void'(hist.pop_front());
                    if (hist.size() == N) begin
                        m_out = m_tt[winVal()]; m_valid = 1'b1;
                    end
                end
            end
            if (tt_load) m_tt = tt_data;
            if (cnt_clr) begin
                m_cnt8 = 0; m_cnt2 = 0;
            end else if (m_valid && m_out) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("out_valid_a", 32'(out_valid_a), 32'(m_valid));
        check("out_valid_b", 32'(out_valid_b), 32'(m_valid));
        check("out_a", 32'(out_a), 32'(m_out));
        check("out_b", 32'(out_b), 32'(m_out));
        check("window_a", 32'(window_a), 32'(winVal()));
        check("window_b", 32'(window_b), 32'(winVal()));
        check("match_cnt_a", 32'(match_cnt_a), 32'(m_cnt8));
        check("match_cnt_b", 32'(match_cnt_b), 32'(m_cnt2));
    endtask

    task automatic applyStimulus(input logic md, input logic v, input logic [3:0] p,
                                 input logic s, input logic ld, input logic [15:0] d,
                                 input logic clr);
        mode = md; in_valid = v; in_par = p; in_ser = s;
        tt_load = ld; tt_data = d; cnt_clr = clr;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_par = '0; in_ser = 1'b0;
        tt_load = 1'b0; tt_data = '0; cnt_clr = 1'b0;
        modelStep();
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput();
    endtask

    initial begin
        logic [5:0] ser_bits;
        logic [5:0] ser_valid;
        logic [5:0] ser_out;
        logic       md;
        n_cmp = 0; n_fail = 0;
        rst = 1'b0;

        // Reset state
        doReset();
        check("rst_out", 32'(out_a), 32'd0);
        check("rst_cnt", 32'(match_cnt_a), 32'd0);

        // Parallel sweep of all inputs with the default function
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 1'b1, 4'(k), 1'b0, 1'b0, 16'h0, 1'b0);
            check("par_minterm", 32'(out_a), 32'(TT_INIT[k]));
        end
        check("par_cnt8", 32'(match_cnt_a), 32'd8);
        check("par_cnt2_sat", 32'(match_cnt_b), 32'd3);

        // Table load uses the old table in the load cycle
        applyStimulus(1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 16'h8000, 1'b0);
        check("load_old_tt", 32'(out_a), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 16'h0, 1'b0);
        check("load_new_tt", 32'(out_a), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, TT_INIT, 1'b0);

        // Clear wins over a matching result
        applyStimulus(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 16'h0, 1'b1);
        check("clr_wins_a", 32'(match_cnt_a), 32'd0);
        check("clr_wins_b", 32'(match_cnt_b), 32'd0);

        // Serial: mode change cycle then bits 1,0,0,1,1,0
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 16'h0, 1'b0);
        check("mode_chg_silent", 32'(out_valid_a), 32'd0);
        ser_bits  = 6'b011001;
        ser_valid = 6'b111000;
        ser_out   = 6'b101000;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 4'd0, ser_bits[i], 1'b0, 16'h0, 1'b0);
            check("ser_valid", 32'(out_valid_a), 32'(ser_valid[i]));
            if (ser_valid[i]) check("ser_out", 32'(out_a), 32'(ser_out[i]));
        end
        check("ser_window", 32'(window_a), 32'd6);

        // Idle cycle holds out and window
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0, 1'b0);
        check("idle_valid", 32'(out_valid_a), 32'd0);
        check("idle_out_hold", 32'(out_a), 32'd1);

        // Mode 1->0 with valid is ignored, then back to serial refills
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 16'h0, 1'b0);
        check("mode_1to0_silent", 32'(out_valid_a), 32'd0);
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 16'h0, 1'b0);
        check("mode_0to1_silent", 32'(out_valid_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 16'h0, 1'b0);
            check("refill_valid", 32'(out_valid_a), (i == 3) ? 32'd1 : 32'd0);
        end

        // Reset mid-stream discards the partial window
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 16'h0, 1'b0);
        doReset();
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 4'd0, 1'(i % 2), 1'b0, 16'h0, 1'b0);
            check("rst_refill_valid", 32'(out_valid_a), (i == 3) ? 32'd1 : 32'd0);
        end
        check("rst_refill_out", 32'(out_a), 32'd1);
        check("rst_refill_win", 32'(window_a), 32'd5);

        // Randomized traffic
        md = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset();
            end else begin
                if ($urandom_range(0, 15) == 0) md = ~md;
                applyStimulus(md, ($urandom_range(0, 3) != 0), 4'($urandom),
                              1'($urandom), ($urandom_range(0, 19) == 0), 16'($urandom),
                              ($urandom_range(0, 24) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
